reaction_ctrl: RTL and testbench



---
 rtl/reaction_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_reaction_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_ctrl
// Description : Master FSM of the reaction-time tester. Drives the state code
//               into the Timer and consumes its handshake flags. Generates
//               the random pre-go delay from a 14-bit Fibonacci LFSR. Detects
//               rising edges on the start and react buttons. Latches the
//               reaction result and the foul/timeout flags.
//
// Optional    : `define REACTION_BEST_EN tracks the best non-timeout result
//               in best_time (reset 999). Without it best_time is tied to 0.
//
// Ports       : clk, rst (sync, active-high)
//               btn_start, btn_react          debounced button levels
//               signal_start/overflow/cleared Timer status flags
//               react_time[9:0]               Timer reaction count
//               machine_state[2:0]            state code to the Timer
//               rand_num[13:0]                pre-go delay target
//               led_go, result_valid, foul    state decodes (registered)
//               result[9:0], timeout          latched round outcome
//               best_time[9:0]                best result (optional)
//
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_ctrl #(
    parameter int          MIN_DELAY = 1000,
    parameter logic [13:0] LFSR_SEED = 14'h2A5B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic        signal_start,
    input  logic        signal_overflow,
    input  logic        signal_cleared,
    input  logic [9:0]  react_time,
    output logic [2:0]  machine_state,
    output logic [13:0] rand_num,
    output logic        led_go,
    output logic [9:0]  result,
    output logic        result_valid,
    output logic        timeout,
    output logic        foul,
    output logic [9:0]  best_time
);

    localparam logic [13:0] c_min_delay = 14'(MIN_DELAY);
    localparam logic [9:0]  c_time_max  = 10'd999;

    // State codes are shared with the Timer and must not be re-encoded.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_CLR_CNT1 = 3'd2,
        S_START    = 3'd3,
        S_RESULT   = 3'd4,
        S_CLR_CNT2 = 3'd5,
        S_FOUL     = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load_rand;
    logic        w_cap_press;
    logic        w_cap_ovf;

    logic [13:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [13:0] r_rand;

    // Button edge detection: level register, history register, and a
    // hold-off flag. The hold-off flag is set by reset and only clears once
    // the raw button is seen released, so a button held through reset never
    // produces a press pulse.
    logic        r_start_lvl;
    logic        r_start_prev;
    logic        r_start_blk;
    logic        r_react_lvl;
    logic        r_react_prev;
    logic        r_react_blk;
    logic        w_start_press;
    logic        w_react_press;

    logic [9:0]  r_result;
    logic        r_timeout;
    logic        r_led_go;
    logic        r_result_valid;
    logic        r_foul;

    assign w_start_press = r_start_lvl & ~r_start_prev & ~r_start_blk;
    assign w_react_press = r_react_lvl & ~r_react_prev & ~r_react_blk;

    // Taps 14,13,12,2 (1-based) of the Fibonacci shift register.
    assign w_lfsr_fb = r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[11] ^ r_lfsr[1];

    // ------------------------------------------------------------------
    // Next-state and capture decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_rand = 1'b0;
        w_cap_press = 1'b0;
        w_cap_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    w_state_nxt = S_CLR_CNT2;
                end
            end
            S_CLR_CNT2: begin
                if (signal_cleared) begin
                    w_state_nxt = S_WAIT;
                    w_load_rand = 1'b1;
                end
            end
            S_WAIT: begin
                // A react press before go is a foul even if go arrives
                // in the same cycle.
                if (w_react_press) begin
                    w_state_nxt = S_FOUL;
                end else if (signal_start) begin
                    w_state_nxt = S_CLR_CNT1;
                end
            end
            S_CLR_CNT1: begin
                if (signal_cleared) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A press coincident with overflow counts as a valid
                // reaction of 999 rather than a timeout.
                if (w_react_press) begin
                    w_state_nxt = S_RESULT;
                    w_cap_press = 1'b1;
                end else if (signal_overflow) begin
                    w_state_nxt = S_RESULT;
                    w_cap_ovf   = 1'b1;
                end
            end
            S_RESULT, S_FOUL: begin
                if (w_start_press) begin
                    w_state_nxt = S_CLR_CNT2;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, LFSR, buttons and latched outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_lfsr         <= LFSR_SEED;
            r_rand         <= c_min_delay;
            r_start_lvl    <= 1'b0;
            r_start_prev   <= 1'b0;
            r_start_blk    <= 1'b1;
            r_react_lvl    <= 1'b0;
            r_react_prev   <= 1'b0;
            r_react_blk    <= 1'b1;
            r_result       <= 10'd0;
            r_timeout      <= 1'b0;
            r_led_go       <= 1'b0;
            r_result_valid <= 1'b0;
            r_foul         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= {r_lfsr[12:0], w_lfsr_fb};

            r_start_lvl  <= btn_start;
            r_start_prev <= r_start_lvl;
            r_start_blk  <= r_start_blk & btn_start;
            r_react_lvl  <= btn_react;
            r_react_prev <= r_react_lvl;
            r_react_blk  <= r_react_blk & btn_react;

            if (w_load_rand) begin
                r_rand <= c_min_delay + {2'b00, r_lfsr[11:0]};
            end

            if (w_cap_press) begin
                r_result  <= react_time;
                r_timeout <= 1'b0;
            end else if (w_cap_ovf) begin
                r_result  <= c_time_max;
                r_timeout <= 1'b1;
            end

            r_led_go       <= (w_state_nxt == S_START);
            r_result_valid <= (w_state_nxt == S_RESULT);
            r_foul         <= (w_state_nxt == S_FOUL);
        end
    end

    // ------------------------------------------------------------------
    // Best-time tracking
    // ------------------------------------------------------------------
`ifdef REACTION_BEST_EN
    logic [9:0] r_best;

    // Only a genuine press can improve the best time; overflow rounds and
    // fouls never reach this path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best <= c_time_max;
        end else if (w_cap_press && (react_time < r_best)) begin
            r_best <= react_time;
        end
    end

    assign best_time = r_best;
`else
    assign best_time = 10'd0;
`endif

    assign machine_state = r_state;
    assign rand_num      = r_rand;
    assign led_go        = r_led_go;
    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign timeout       = r_timeout;
    assign foul          = r_foul;

endmodule
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_ctrl
// Description : Self-checking bench for reaction_ctrl. Each scenario task
//               drives the button/Timer inputs, pushes the expected output
//               snapshot to a scoreboard queue, and pops/compares it once the
//               DUT has responded. Honours `define REACTION_BEST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_ctrl;

    localparam logic [13:0] c_seed = 14'h2A5B;
`ifdef REACTION_BEST_EN
    localparam logic [9:0]  c_best_rst = 10'd999;
    localparam bit          c_best_en  = 1'b1;
`else
    localparam logic [9:0]  c_best_rst = 10'd0;
    localparam bit          c_best_en  = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_react;
    logic        signal_start;
    logic        signal_overflow;
    logic        signal_cleared;
    logic [9:0]  react_time;
    logic [2:0]  machine_state;
    logic [13:0] rand_num;
    logic        led_go;
    logic [9:0]  result;
    logic        result_valid;
    logic        timeout;
    logic        foul;
    logic [9:0]  best_time;

    reaction_ctrl #(
        .MIN_DELAY (1000),
        .LFSR_SEED (c_seed)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_start       (btn_start),
        .btn_react       (btn_react),
        .signal_start    (signal_start),
        .signal_overflow (signal_overflow),
        .signal_cleared  (signal_cleared),
        .react_time      (react_time),
        .machine_state   (machine_state),
        .rand_num        (rand_num),
        .led_go          (led_go),
        .result          (result),
        .result_valid    (result_valid),
        .timeout         (timeout),
        .foul            (foul),
        .best_time       (best_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, reset and advanced exactly as the delay source is
    // described: seed on reset, shift every clock otherwise.
    logic [13:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= c_seed;
        else     m_lfsr <= {m_lfsr[12:0], m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[11] ^ m_lfsr[1]};
    end

    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  res;
        logic        tmo;
        logic        rv;
        logic        fl;
        logic        go;
        logic [9:0]  best;
        logic [13:0] rn;
    } snap_t;

    snap_t       exp_q[$];
    int          checks;
    int          errors;
    logic [13:0] exp_rn;
    logic [9:0]  exp_best;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [2:0] st, input logic [9:0] res, input logic tmo);
        snap_t e;
        e.st   = st;
        e.res  = res;
        e.tmo  = tmo;
        e.rv   = (st == 3'd4);
        e.fl   = (st == 3'd6);
        e.go   = (st == 3'd3);
        e.best = exp_best;
        e.rn   = exp_rn;
        exp_q.push_back(e);
    endtask

    function automatic snap_t observe();
        snap_t o;
        o.st   = machine_state;
        o.res  = result;
        o.tmo  = timeout;
        o.rv   = result_valid;
        o.fl   = foul;
        o.go   = led_go;
        o.best = best_time;
        o.rn   = rand_num;
        return o;
    endfunction

    // Single start-button press: one cycle to register the level, the
    // state moves on the following edge.
    task automatic press_start();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
    endtask

    // Walk from RESULT/FOUL through a full round up to START.
    task automatic go_to_start();
        press_start();
        signal_cleared = 1'b1;
        exp_rn = 14'd1000 + {2'b00, m_lfsr[11:0]};
        step();
        signal_cleared = 1'b0;
        signal_start = 1'b1;
        step();
        signal_start = 1'b0;
        signal_cleared = 1'b1;
        step();
        signal_cleared = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b1;
        btn_start = 1'b0; btn_react = 1'b0;
        signal_start = 1'b0; signal_overflow = 1'b0; signal_cleared = 1'b0;
        react_time = 10'd0;
        step();
        step();
        rst = 1'b0;
        exp_rn = 14'd1000;
        exp_best = c_best_rst;
        sb_push(3'd0, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset: got %h expected %h", o, e); end
    endtask

    task automatic test_start_to_wait();
        snap_t e, o;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        sb_push(3'd5, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL idle_to_clr2: got %h expected %h", o, e); end

        signal_cleared = 1'b1;
        exp_rn = 14'd1000 + {2'b00, m_lfsr[11:0]};
        sb_push(3'd1, 10'd0, 1'b0);
        step();
        signal_cleared = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL clr2_to_wait: got %h expected %h", o, e); end
        checks++;
        if (rand_num < 14'd1000 || rand_num > 14'd5095) begin
            errors++; $display("FAIL rand_range: got %0d required 1000..5095", rand_num);
        end

        press_start();
        sb_push(3'd1, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL start_ignored_wait: got %h expected %h", o, e); end
    endtask

    task automatic test_react();
        snap_t e, o;
        signal_start = 1'b1;
        sb_push(3'd2, 10'd0, 1'b0);
        step();
        signal_start = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL wait_to_clr1: got %h expected %h", o, e); end

        btn_react = 1'b1;
        step();
        btn_react = 1'b0;
        sb_push(3'd2, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL react_ignored_clr1: got %h expected %h", o, e); end

        signal_cleared = 1'b1;
        sb_push(3'd3, 10'd0, 1'b0);
        step();
        signal_cleared = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL clr1_to_start: got %h expected %h", o, e); end

        react_time = 10'd237;
        btn_react = 1'b1;
        step();
        btn_react = 1'b0;
        if (c_best_en) exp_best = 10'd237;
        sb_push(3'd4, 10'd237, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL react_result: got %h expected %h", o, e); end
    endtask

    task automatic test_foul();
        snap_t e, o;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        sb_push(3'd5, 10'd237, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL result_to_clr2: got %h expected %h", o, e); end

        signal_cleared = 1'b1;
        exp_rn = 14'd1000 + {2'b00, m_lfsr[11:0]};
        sb_push(3'd1, 10'd237, 1'b0);
        step();
        signal_cleared = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL second_wait: got %h expected %h", o, e); end

        btn_react = 1'b1;
        step();
        btn_react = 1'b0;
        signal_start = 1'b1;
        sb_push(3'd6, 10'd237, 1'b0);
        step();
        signal_start = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL foul_priority: got %h expected %h", o, e); end
    endtask

    task automatic test_overflow();
        snap_t e, o;
        go_to_start();
        sb_push(3'd3, 10'd237, 1'b0);
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL reach_start: got %h expected %h", o, e); end

        react_time = 10'd500;
        signal_overflow = 1'b1;
        sb_push(3'd4, 10'd999, 1'b1);
        step();
        signal_overflow = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL overflow: got %h expected %h", o, e); end
    endtask

    task automatic test_press_and_overflow();
        snap_t e, o;
        go_to_start();
        react_time = 10'd999;
        btn_react = 1'b1;
        step();
        btn_react = 1'b0;
        signal_overflow = 1'b1;
        sb_push(3'd4, 10'd999, 1'b0);
        step();
        signal_overflow = 1'b0;
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL press_and_overflow: got %h expected %h", o, e); end
    endtask

    task automatic test_reset_mid_round();
        snap_t e, o;
        go_to_start();
        sb_push(3'd3, 10'd999, 1'b0);
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL start_before_rst: got %h expected %h", o, e); end

        btn_react = 1'b1;
        btn_start = 1'b1;
        rst = 1'b1;
        exp_rn = 14'd1000;
        exp_best = c_best_rst;
        sb_push(3'd0, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL rst_mid_round: got %h expected %h", o, e); end

        step();
        rst = 1'b0;
        step();
        step();
        sb_push(3'd0, 10'd0, 1'b0);
        step();
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL held_buttons_no_press: got %h expected %h", o, e); end

        btn_start = 1'b0;
        btn_react = 1'b0;
        step();
        press_start();
        sb_push(3'd5, 10'd0, 1'b0);
        e = exp_q.pop_front(); o = observe(); checks++;
        if (o !== e) begin errors++; $display("FAIL press_after_release: got %h expected %h", o, e); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start_to_wait();
        test_react();
        test_foul();
        test_overflow();
        test_press_and_overflow();
        test_reset_mid_round();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
